// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and a parameter
// legality check used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic bit uart_cfg_check(input int unsigned cpb,
                                        input int unsigned db,
                                        input int unsigned par,
                                        input int unsigned sb);
    return (cpb >= 2) && (db >= 5) && (db <= 9) && (par <= PARITY_EVEN) &&
           ((sb == 1) || (sb == 2));
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake between a byte source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of each serial bit.
// Held at zero while restart is high so the first bit is a full period.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bit_tick = (r_cnt == LAST) && !restart;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first payload, optional
// parity and 1/2 stop bits; one word per valid/ready handshake.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_cfg_if.slave bus,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done
);

  if (!uart_cfg_check(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end

  localparam int unsigned    BCW       = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BCW-1:0]       r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par;
  logic                 r_tx, r_tx_ready, r_tx_busy, r_tx_done;
  logic                 w_tick, w_accept, w_tx_nxt, w_done_nxt, w_par_calc;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (r_state == ST_IDLE),
    .bit_tick (w_tick)
  );

  assign w_accept   = bus.tx_valid && r_tx_ready;
  assign w_par_calc = (PARITY == PARITY_ODD) ? ~^bus.tx_data : ^bus.tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
      ST_START:  if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_tick && (r_bit_cnt == LAST_BIT))
                   w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tick && (r_stop_cnt == LAST_STOP)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered pins change
  // on the same edge as the state, with no path from tx_valid to the pins.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept)                          w_shift_nxt = bus.tx_data;
    else if ((r_state == ST_DATA) && w_tick) w_shift_nxt = r_shift >> 1;

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = r_par;
      default:   w_tx_nxt = 1'b1;
    endcase

    w_done_nxt = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_par      <= w_par_calc;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end else if (w_tick) begin
        if (r_state == ST_DATA)
          r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BCW'(1);
        if (r_state == ST_STOP)
          r_stop_cnt <= (r_stop_cnt == LAST_STOP) ? 1'b0 : 1'b1;
      end
      r_tx       <= w_tx_nxt;
      r_tx_ready <= (w_state_nxt == ST_IDLE);
      r_tx_busy  <= (w_state_nxt != ST_IDLE);
      r_tx_done  <= w_done_nxt;
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign tx           = r_tx;
  assign tx_busy      = r_tx_busy;
  assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) checked
// every cycle against a frame-level model, plus literal frame expectations.
module tb_uart_tx_cfg;

  localparam int CPB = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PA [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] v = '0;
  logic [8:0] d [4];
  logic [3:0] tx_o, rdy, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_d ();

  assign if_a.tx_valid = v[0];  assign if_a.tx_data = d[0][7:0];  assign rdy[0] = if_a.tx_ready;
  assign if_b.tx_valid = v[1];  assign if_b.tx_data = d[1][7:0];  assign rdy[1] = if_b.tx_ready;
  assign if_c.tx_valid = v[2];  assign if_c.tx_data = d[2][7:0];  assign rdy[2] = if_c.tx_ready;
  assign if_d.tx_valid = v[3];  assign if_d.tx_data = d[3][6:0];  assign rdy[3] = if_d.tx_ready;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a), .tx(tx_o[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .bus(if_b), .tx(tx_o[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .bus(if_c), .tx(tx_o[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .reset(reset), .bus(if_d), .tx(tx_o[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  // Frame as a bit list: start 0, payload LSB first, parity, stop 1s.
  function automatic logic [15:0] build_frame(input int db, input int pa, input int sb,
                                              input logic [8:0] dat, output int len);
    logic [15:0] f;
    int ones, n;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = dat[i];
      ones += int'(dat[i]);
    end
    n = 1 + db;
    if (pa != 0) begin
      f[n] = (pa == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      n++;
    end
    len = (n + sb) * CPB;
    return f;
  endfunction

  int          m_active [4] = '{default: 0};
  int          m_k      [4] = '{default: 0};
  int          m_len    [4] = '{default: 0};
  logic        m_done   [4] = '{default: 1'b0};
  logic [15:0] m_frame  [4] = '{default: '1};

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_active[i] = 0;
        m_done[i]   = 1'b0;
      end else if (m_active[i] != 0) begin
        m_k[i]++;
        if (m_k[i] == m_len[i]) begin
          m_active[i] = 0;
          m_done[i]   = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (v[i]) begin
          m_frame[i]  = build_frame(DB[i], PA[i], SB[i], d[i], m_len[i]);
          m_active[i] = 1;
          m_k[i]      = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic e_tx;
      e_tx = (m_active[i] != 0) ? m_frame[i][m_k[i] / CPB] : 1'b1;
      chk("tx",    i, 32'(tx_o[i]), 32'(e_tx));
      chk("ready", i, 32'(rdy[i]),  32'(m_active[i] == 0));
      chk("busy",  i, 32'(busy[i]), 32'(m_active[i] != 0));
      chk("done",  i, 32'(done[i]), 32'(m_done[i]));
    end
  end

  // Called at the first falling edge after acceptance (cycle 0 of the frame).
  task automatic sample_frame(input int inst, input logic [8:0] tog, input bit stop_on_done,
                              input bit pulse_valid, output logic [15:0] bits,
                              output int dc, output int npulse);
    bits = '0;
    dc = -1;
    npulse = 0;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clk);
      if ((n % CPB == 1) && (n / CPB < 16)) bits[n / CPB] = tx_o[inst];
      if (n == 10) d[inst] = tog;
      if (pulse_valid && n == 12) v[inst] = 1'b1;
      if (pulse_valid && n == 14) v[inst] = 1'b0;
      if (done[inst]) begin
        npulse++;
        if (dc < 0) dc = n;
        if (stop_on_done) break;
      end
    end
  endtask

  task automatic run_frame(input int inst, input logic [8:0] dat, output logic [15:0] bits,
                           output int dc, output int npulse);
    @(negedge clk);
    chk("ready_before_send", inst, 32'(rdy[inst]), 32'd1);
    v[inst] = 1'b1;
    d[inst] = dat;
    @(negedge clk);
    v[inst] = 1'b0;
    sample_frame(inst, ~dat, 1'b0, 1'b1, bits, dc, npulse);
  endtask

  initial begin
    logic [15:0] bits;
    int dc, np;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // 1. async reset values
    #2 reset = 1'b1;
    #1;
    chk("rst_tx", 0, 32'(tx_o[0]), 32'd1);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_done", 0, 32'(done[0]), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tx", 3, 32'(tx_o[3]), 32'd1);
    chk("idle_ready", 3, 32'(rdy[3]), 32'd1);

    // 2. 8N1 0xA5
    run_frame(0, 9'h0A5, bits, dc, np);
    chk("a5_bits", 0, 32'(bits[9:0]), 32'h34A);
    chk("a5_done_cycle", 0, 32'(dc), 32'd40);
    chk("a5_done_pulses", 0, 32'(np), 32'd1);

    // 3. parity variants
    run_frame(1, 9'h007, bits, dc, np);
    chk("even07_bits", 1, 32'(bits[10:0]), 32'h60E);
    chk("even07_par", 1, 32'(bits[9]), 32'd1);
    chk("even07_done_cycle", 1, 32'(dc), 32'd44);
    run_frame(2, 9'h007, bits, dc, np);
    chk("odd07_par", 2, 32'(bits[9]), 32'd0);
    chk("odd07_done_cycle", 2, 32'(dc), 32'd44);
    run_frame(1, 9'h000, bits, dc, np);
    chk("even00_par", 1, 32'(bits[9]), 32'd0);

    // 4. 7 data bits, 2 stop bits
    run_frame(3, 9'h041, bits, dc, np);
    chk("d41_bits", 3, 32'(bits[9:0]), 32'h382);
    chk("d41_done_cycle", 3, 32'(dc), 32'd40);
    chk("d41_done_pulses", 3, 32'(np), 32'd1);

    // 5. back-to-back with tx_valid held high
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 9'h055;
    @(negedge clk);
    sample_frame(0, 9'h0AA, 1'b1, 1'b0, bits, dc, np);
    chk("b2b_first_bits", 0, 32'(bits[9:0]), 32'h2AA);
    chk("b2b_first_done", 0, 32'(dc), 32'd40);
    chk("b2b_ready_at_done", 0, 32'(rdy[0]), 32'd1);
    @(negedge clk);
    chk("b2b_start_bit", 0, 32'(tx_o[0]), 32'd0);
    chk("b2b_busy", 0, 32'(busy[0]), 32'd1);
    v[0] = 1'b0;
    sample_frame(0, 9'h012, 1'b0, 1'b1, bits, dc, np);
    chk("b2b_second_bits", 0, 32'(bits[9:0]), 32'h354);
    chk("b2b_second_done", 0, 32'(dc), 32'd40);

    // 6. reset during data bit 3 of 0xFF, then a clean frame
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 9'h0FF;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx", 0, 32'(tx_o[0]), 32'd1);
    chk("midrst_ready", 0, 32'(rdy[0]), 32'd1);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame(0, 9'h03C, bits, dc, np);
    chk("x3c_bits", 0, 32'(bits[9:0]), 32'h278);
    chk("x3c_done_cycle", 0, 32'(dc), 32'd40);
    chk("x3c_done_pulses", 0, 32'(np), 32'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
